// File: rtl/operand_stage.sv
// operand_stage: rename lookup and operand capture ahead of issue.
//
// An instruction is accepted when the stage is empty, or when the instruction
// it holds leaves in the same cycle. Each source register is resolved through
// the rename table. An unrenamed register reads the register file. A renamed
// register reads the bypass network, then the ROB read port. If neither holds
// the value, the source waits on its ROB tag. While waiting, the stage watches
// the bypass network and the ROB port every cycle until both operands arrive.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   in_valid/in_ready             upstream handshake
//   in_rs1/in_rs2/in_rd           source and destination register indices
//   in_writes_rd, in_payload      destination-write flag, opaque decoded fields
//   rf_s1_data/rf_s2_data         register-file read data for in_rs1/in_rs2
//   rob_full, assigned_rob_id     ROB allocation status and tag for this instr
//   rob_sX_id/_data/_valid        combinational ROB value-read ports
//   byp_data/byp_rob_id/byp_valid packed bypass channels, channel 0 first
//   commit_valid/rd/rob_id        retirement notification, clears stale renames
//   flush                         discards everything and clears all renames
//   out_valid/out_ready           downstream handshake
//   s1/s2_data_out, payload_out   captured operands and payload
//   rob_id_out                    ROB tag carried with the instruction
//   require_rob_entry             ROB allocation request on accept

module operand_stage #(
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned ROB_ENTRY_WIDTH = 4,
    parameter int unsigned NUM_BYPASS      = 6,
    parameter int unsigned REG_INDEX_SIZE  = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [REG_INDEX_SIZE-1:0]             in_rs1,
    input  logic [REG_INDEX_SIZE-1:0]             in_rs2,
    input  logic [REG_INDEX_SIZE-1:0]             in_rd,
    input  logic                                  in_writes_rd,
    input  logic [63:0]                           in_payload,

    input  logic [WORD_SIZE-1:0]                  rf_s1_data,
    input  logic [WORD_SIZE-1:0]                  rf_s2_data,

    input  logic                                  rob_full,
    input  logic [ROB_ENTRY_WIDTH-1:0]            assigned_rob_id,
    output logic [ROB_ENTRY_WIDTH-1:0]            rob_s1_id,
    output logic [ROB_ENTRY_WIDTH-1:0]            rob_s2_id,
    input  logic [WORD_SIZE-1:0]                  rob_s1_data,
    input  logic [WORD_SIZE-1:0]                  rob_s2_data,
    input  logic                                  rob_s1_valid,
    input  logic                                  rob_s2_valid,

    input  logic [NUM_BYPASS*WORD_SIZE-1:0]       byp_data,
    input  logic [NUM_BYPASS*ROB_ENTRY_WIDTH-1:0] byp_rob_id,
    input  logic [NUM_BYPASS-1:0]                 byp_valid,

    input  logic                                  commit_valid,
    input  logic [REG_INDEX_SIZE-1:0]             commit_rd,
    input  logic [ROB_ENTRY_WIDTH-1:0]            commit_rob_id,
    input  logic                                  flush,

    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WORD_SIZE-1:0]                  s1_data_out,
    output logic [WORD_SIZE-1:0]                  s2_data_out,
    output logic [63:0]                           payload_out,
    output logic [ROB_ENTRY_WIDTH-1:0]            rob_id_out,
    output logic                                  require_rob_entry
);

    localparam int unsigned NumRegs = 1 << REG_INDEX_SIZE;

    typedef enum logic [1:0] {
        StEmpty,
        StWait,
        StReady
    } state_e;

    state_e state_q, state_d;

    // Rename table
    logic [NumRegs-1:0]         tbl_valid_q, tbl_valid_d;
    logic [ROB_ENTRY_WIDTH-1:0] tbl_tag_q [NumRegs];
    logic [ROB_ENTRY_WIDTH-1:0] tbl_tag_d [NumRegs];

    // Captured instruction
    logic [WORD_SIZE-1:0]       s1_q, s1_d, s2_q, s2_d;
    logic                       s1_pend_q, s1_pend_d, s2_pend_q, s2_pend_d;
    logic [ROB_ENTRY_WIDTH-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic [63:0]                payload_q, payload_d;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id_q, rob_id_d;

    // Tag lookup
    logic [ROB_ENTRY_WIDTH-1:0] s1_look_tag, s2_look_tag;
    logic                       s1_byp_hit, s2_byp_hit;
    logic [WORD_SIZE-1:0]       s1_byp_data, s2_byp_data;
    logic                       s1_avail, s2_avail;
    logic [WORD_SIZE-1:0]       s1_avail_data, s2_avail_data;

    logic accept;

    // rst gates in_ready so nothing is accepted while reset is held.
    assign in_ready = rst && !rob_full && !flush &&
                      (state_q == StEmpty || (state_q == StReady && out_ready));
    assign accept   = in_valid && in_ready;

    assign require_rob_entry = accept && in_writes_rd;
    assign out_valid         = (state_q == StReady);
    assign s1_data_out       = s1_q;
    assign s2_data_out       = s2_q;
    assign payload_out       = payload_q;
    assign rob_id_out        = rob_id_q;

    // While waiting, in_ready is low, so the lookup tag follows the pending tag.
    // Otherwise it follows the rename of the incoming source register.
    assign s1_look_tag = (state_q == StWait) ? s1_tag_q : tbl_tag_q[in_rs1];
    assign s2_look_tag = (state_q == StWait) ? s2_tag_q : tbl_tag_q[in_rs2];
    assign rob_s1_id   = s1_look_tag;
    assign rob_s2_id   = s2_look_tag;

    // Scan from the highest channel down, so the lowest matching channel wins.
    always_comb begin
        s1_byp_hit  = 1'b0;
        s1_byp_data = '0;
        s2_byp_hit  = 1'b0;
        s2_byp_data = '0;
        for (int i = int'(NUM_BYPASS) - 1; i >= 0; i--) begin
            if (byp_valid[i] &&
                byp_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] == s1_look_tag) begin
                s1_byp_hit  = 1'b1;
                s1_byp_data = byp_data[i*WORD_SIZE +: WORD_SIZE];
            end
            if (byp_valid[i] &&
                byp_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH] == s2_look_tag) begin
                s2_byp_hit  = 1'b1;
                s2_byp_data = byp_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign s1_avail      = s1_byp_hit || rob_s1_valid;
    assign s2_avail      = s2_byp_hit || rob_s2_valid;
    assign s1_avail_data = s1_byp_hit ? s1_byp_data : rob_s1_data;
    assign s2_avail_data = s2_byp_hit ? s2_byp_data : rob_s2_data;

    always_comb begin
        state_d     = state_q;
        tbl_valid_d = tbl_valid_q;
        tbl_tag_d   = tbl_tag_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        s1_pend_d   = s1_pend_q;
        s2_pend_d   = s2_pend_q;
        s1_tag_d    = s1_tag_q;
        s2_tag_d    = s2_tag_q;
        payload_d   = payload_q;
        rob_id_d    = rob_id_q;

        // Only the producer that still owns the mapping may retire it.
        if (commit_valid && tbl_valid_q[commit_rd] &&
            tbl_tag_q[commit_rd] == commit_rob_id) begin
            tbl_valid_d[commit_rd] = 1'b0;
        end

        unique case (state_q)
            StEmpty: ;
            StWait: begin
                if (s1_pend_q && s1_avail) begin
                    s1_d      = s1_avail_data;
                    s1_pend_d = 1'b0;
                end
                if (s2_pend_q && s2_avail) begin
                    s2_d      = s2_avail_data;
                    s2_pend_d = 1'b0;
                end
                if (!s1_pend_d && !s2_pend_d) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (accept) begin
            payload_d = in_payload;
            rob_id_d  = assigned_rob_id;

            // Sources read the table as it was before this instruction's rename.
            if (!tbl_valid_q[in_rs1]) begin
                s1_d      = rf_s1_data;
                s1_pend_d = 1'b0;
            end else if (s1_avail) begin
                s1_d      = s1_avail_data;
                s1_pend_d = 1'b0;
            end else begin
                s1_pend_d = 1'b1;
                s1_tag_d  = s1_look_tag;
            end

            if (!tbl_valid_q[in_rs2]) begin
                s2_d      = rf_s2_data;
                s2_pend_d = 1'b0;
            end else if (s2_avail) begin
                s2_d      = s2_avail_data;
                s2_pend_d = 1'b0;
            end else begin
                s2_pend_d = 1'b1;
                s2_tag_d  = s2_look_tag;
            end

            state_d = (s1_pend_d || s2_pend_d) ? StWait : StReady;

            // Applied after the commit clear, so a same-cycle rename wins.
            if (in_writes_rd && in_rd != '0) begin
                tbl_valid_d[in_rd] = 1'b1;
                tbl_tag_d[in_rd]   = assigned_rob_id;
            end
        end

        if (flush) begin
            tbl_valid_d = '0;
            state_d     = StEmpty;
            s1_pend_d   = 1'b0;
            s2_pend_d   = 1'b0;
        end

        tbl_valid_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StEmpty;
            tbl_valid_q <= '0;
            tbl_tag_q   <= '{default: '0};
            s1_q        <= '0;
            s2_q        <= '0;
            s1_pend_q   <= 1'b0;
            s2_pend_q   <= 1'b0;
            s1_tag_q    <= '0;
            s2_tag_q    <= '0;
            payload_q   <= '0;
            rob_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_tag_q   <= tbl_tag_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s1_pend_q   <= s1_pend_d;
            s2_pend_q   <= s2_pend_d;
            s1_tag_q    <= s1_tag_d;
            s2_tag_q    <= s2_tag_d;
            payload_q   <= payload_d;
            rob_id_q    <= rob_id_d;
        end
    end

endmodule
